// File: rtl/dw_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package dw_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dw_arb_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req searching
// from ptr+1 upwards, wrapping modulo N.
module dw_arb_rr_pick
  import dw_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index
);

  localparam logic [IW+1:0] N_V = (IW+2)'(N);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IW+1:0]  start_s;
  logic [IW+1:0]  off_s;
  logic [IW+1:0]  sum_s;

  // Rotate the doubled request so bit 0 is the client just after ptr, then
  // priority-encode the lowest set bit and map it back to a client index.
  always_comb begin
    dbl_s   = {req, req};
    start_s = {2'b00, ptr} + (IW+2)'(1'b1);
    rot_s   = N'(dbl_s >> start_s);
    off_s   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? (IW+2)'(j) : off_s;
    end
    sum_s = start_s + off_s;
    if (sum_s >= N_V) begin
      sum_s = sum_s - N_V;
    end else begin
      sum_s = sum_s;
    end
    valid  = |rot_s;
    index  = valid ? sum_s[IW-1:0] : '0;
    onehot = valid ? (N'(1'b1) << index) : '0;
  end

endmodule

// File: rtl/dw_arb_wrr.sv
// Weighted round-robin arbiter with per-client burst credit and grant lock.
// All outputs come straight from registers.
module dw_arb_wrr
  import dw_arb_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  WW = 4,
  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_n,
  input  logic          enable,
  input  logic [N-1:0]  request,
  input  logic [N-1:0]  mask,
  input  logic [N-1:0]  lock,
  input  logic [N*WW-1:0] weight,
  output logic          granted,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index
);

  localparam logic [WW-1:0] CNT_ONE  = WW'(1'b1);
  localparam logic [IW-1:0] PTR_LAST = IW'(N - 1);

  arb_state_e    state_r, state_nxt_s;
  logic [N-1:0]  grant_r, grant_nxt_s;
  logic [IW-1:0] gidx_r, gidx_nxt_s;
  logic [IW-1:0] ptr_r, ptr_nxt_s;
  logic [WW-1:0] cnt_r, cnt_nxt_s;

  logic [N-1:0]  mreq_s;
  logic          pick_valid_s;
  logic [N-1:0]  pick_onehot_s;
  logic [IW-1:0] pick_index_s;
  logic [WW-1:0] weight_sel_s;
  logic          hold_s;

  assign mreq_s = request & ~mask;

  dw_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (mreq_s),
    .ptr    (ptr_r),
    .valid  (pick_valid_s),
    .onehot (pick_onehot_s),
    .index  (pick_index_s)
  );

  // Hold decision and credit of the candidate winner (weight 0 counts as 1).
  always_comb begin
    weight_sel_s = weight[pick_index_s*WW +: WW];
    if (weight_sel_s == '0) begin
      weight_sel_s = CNT_ONE;
    end else begin
      weight_sel_s = weight_sel_s;
    end
    hold_s = (state_r == GRANT) && enable && mreq_s[gidx_r] &&
             (lock[gidx_r] || (cnt_r > CNT_ONE));
  end

  // Next-state: disable clears, hold burns credit, otherwise re-arbitrate.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    gidx_nxt_s  = gidx_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    if (!enable) begin
      state_nxt_s = IDLE;
      grant_nxt_s = '0;
      gidx_nxt_s  = '0;
      cnt_nxt_s   = '0;
    end else if (hold_s) begin
      cnt_nxt_s = (cnt_r > CNT_ONE) ? (cnt_r - CNT_ONE) : CNT_ONE;
    end else if (pick_valid_s) begin
      state_nxt_s = GRANT;
      grant_nxt_s = pick_onehot_s;
      gidx_nxt_s  = pick_index_s;
      ptr_nxt_s   = pick_index_s;
      cnt_nxt_s   = weight_sel_s;
    end else begin
      state_nxt_s = IDLE;
      grant_nxt_s = '0;
      gidx_nxt_s  = '0;
      cnt_nxt_s   = '0;
    end
  end

  // State registers; init_n is a synchronous clear with top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      ptr_r   <= PTR_LAST;
      cnt_r   <= '0;
    end else if (!init_n) begin
      state_r <= IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      ptr_r   <= PTR_LAST;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      gidx_r  <= gidx_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign granted     = (state_r == GRANT);
  assign grant       = grant_r;
  assign grant_index = gidx_r;

endmodule

// File: doc/dw_arb_wrr.md
# dw_arb_wrr

Weighted round-robin arbiter with burst credits and grant lock, sharing one downstream resource (bus port, memory bank, DMA channel) among N clients. It sits immediately upstream of the shared resource. A winner keeps the grant for up to `weight` consecutive cycles, or indefinitely while it asserts `lock`; the grant then passes round-robin to the next masked requester with no bubble cycle. All outputs are registered.

## Interface
- `N`, default 4: number of clients, range 2–32.
- `WW`, default 4: width of each per-client weight field.
- `IW`, derived: ceil(log2(N)), minimum 1. Width of `grant_index`.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: **reset, asynchronous, active-high**.
- `init_n`, input, 1: synchronous clear, active-low. Same effect as `rst`.
- `enable`, input, 1: arbitration enable.
- `request`, input, N: client requests, level-sensitive.
- `mask`, input, N: `mask[i]=1` blocks `request[i]`.
- `lock`, input, N: `lock[i]=1` holds an existing grant to client i.
- `weight`, input, N*WW: client i burst credit in bits `[i*WW +: WW]`. Value 0 is treated as 1.
- `granted`, output, 1: a grant is active.
- `grant`, output, N: one-hot grant, or all zeros.
- `grant_index`, output, IW: index of the granted client; 0 when `granted=0`.

## Operation
- Masked request is `mreq = request & ~mask`.
- **State**
  - `grant_r`, `gidx_r`, credit counter `cnt_r` (WW bits), last-winner pointer `ptr_r`, and FSM {IDLE, GRANT}.
  - `granted` is high exactly when the FSM is in GRANT.
- **Hold condition**, evaluated when in GRANT: `enable && mreq[gidx_r] && (lock[gidx_r] || cnt_r > 1)`.
  - When holding, the grant is unchanged.
  - `cnt_r` decrements, with a floor of 1.
- **Arbitration** runs when in IDLE, or in GRANT when the hold condition is false.
  - Search order is `ptr_r+1`, `ptr_r+2`, … modulo N, wrapping from N-1 to 0.
  - The first `mreq` bit found in that order wins.
  - On a winner w:
    - `grant_r` becomes one-hot(w).
    - `gidx_r` and `ptr_r` become w.
    - `cnt_r` becomes max(weight[w], 1).
    - The FSM goes to GRANT.
  - If the current holder is the only requester, it re-wins and its credit is reloaded.
  - With no winner: the grant clears, the FSM goes to IDLE, `cnt_r` becomes 0, and `ptr_r` is retained.
- `enable=0`: the grant clears on the next edge, the FSM goes to IDLE, and `ptr_r` is retained.
- Masking the holder, or the holder dropping its request, releases the grant at the next edge regardless of `lock` or remaining credit.
- `lock` from a client that is not currently granted is ignored.
- Weights are sampled only when a grant is loaded. Changing a weight mid-burst does not affect the current burst.
- Reset or `init_n=0`:
  - `grant=0`, `granted=0`, `grant_index=0`, `cnt_r=0`, FSM=IDLE.
  - `ptr_r=N-1`, so client 0 has first priority.
  - `init_n` takes precedence over all other inputs.

## Timing
- `mreq` sampled at edge t produces `grant` valid in cycle t+1. Latency is 1 cycle.
- With `request` held and `lock` low, client w holds the grant for exactly `max(weight[w],1)` consecutive cycles.
- Handover from one client to the next happens in a single edge, with no idle cycle between bursts.
- A locked holder keeps the grant through any number of cycles. After `lock` deasserts with credit exhausted, the grant releases at the next edge.
- Simultaneous expiry and new requests are handled in the same cycle's arbitration.
- The search starts after the just-expired holder, so a continuously requesting client cannot starve the others.
- `rst` asserted mid-burst clears the outputs asynchronously.

## Structure
- **Package `dw_arb_pkg`:**
  - `clog2` function.
  - State enum {IDLE, GRANT}.
- **Sub-module `dw_arb_rr_pick`:** combinational rotating-priority picker.
  - Inputs: `req[N]`, `ptr[IW]`.
  - Outputs: `valid`, `onehot[N]`, `index[IW]`.
  - Implemented as a double-width request vector shifted by `ptr+1`, then a priority encode.
- **Top level:** FSM, credit counter, pointer register and output registers. Target size is about 200 lines.

## Test plan
1. **Round robin, weight 1.** N=4, all weights 1, `request=4'b1111` held. Grant sequence is 0,1,2,3,0… one cycle each; `granted` stays high throughout.
2. **Weighted bursts.** weight={3,1,2,0}, all requesting. Client 0 for 3 cycles, client 1 for 1, client 2 for 2, client 3 for 1 (weight 0 treated as 1), then repeat. Consecutive grants have no gap.
3. **Lock.** Client 1 granted with weight 2 and `lock[1]` held for 6 cycles while client 2 requests. Grant stays at 1 for 6 cycles and moves to 2 at the edge after `lock[1]` falls.
4. **Release on mask or request drop.** Client 0 mid-burst with credit 3 left; `mask[0]` goes high. Grant moves to the next requester at the next edge, or goes to 0 with `granted=0` if none is requesting.
5. **Reset and init.**
   - Assert `rst` mid-burst: outputs go to 0 immediately.
   - After release with all requesting: first grant goes to client 0.
   - Repeat with `init_n=0` for one cycle: identical result.
6. **Enable and single requester.** Pulse `enable=0` for one cycle: grant clears, then resumes from `ptr_r+1`. With only client 2 requesting at weight 2: continuous grant to 2, with credit reloaded every 2 cycles.
